// File: rtl/lbist_controller.sv
// rtl/lbist_controller.sv - logic BIST session controller: LFSR pattern source, 16-bit MISR, golden compare
module lbist_controller #(
    parameter int unsigned PAT_COUNT  = 256,
    parameter logic [35:0] LFSR_SEED  = 36'h0_0000_0001,
    parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [6:0]  cut_out,
    output logic [35:0] cut_in,
    output logic        test_mode,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_COMPARE,
        ST_DONE
    } state_t;

    // An all-zero seed would lock the LFSR, so substitute 1.
    localparam logic [35:0] SEED_EFF = (LFSR_SEED == 36'h0) ? 36'h1 : LFSR_SEED;
    localparam logic [15:0] LAST_IDX = 16'(PAT_COUNT - 1);

    state_t      r_state;
    logic [35:0] r_lfsr;
    logic [15:0] r_misr;
    logic [15:0] r_count;
    logic [35:0] r_cut_in;
    logic        r_test_mode;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;

    logic [35:0] w_lfsr_next;
    logic [15:0] w_misr_next;
    logic        w_last;

    assign w_lfsr_next = {r_lfsr[34:0], r_lfsr[35] ^ r_lfsr[24]};
    assign w_misr_next = {r_misr[14:0], r_misr[15] ^ r_misr[14] ^ r_misr[12] ^ r_misr[3]}
                         ^ {9'b0, cut_out};
    assign w_last      = (r_count == LAST_IDX);

    // Session FSM; outputs are registered alongside the state so they change only with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_lfsr      <= 36'h0;
            r_misr      <= 16'h0;
            r_count     <= 16'h0;
            r_cut_in    <= 36'h0;
            r_test_mode <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else if (abort && (r_state != ST_IDLE)) begin
            // Abort wins over every transition; MISR is left as captured so far.
            r_state     <= ST_IDLE;
            r_cut_in    <= 36'h0;
            r_test_mode <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        r_state     <= ST_INIT;
                        r_test_mode <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                ST_INIT: begin
                    r_lfsr   <= SEED_EFF;
                    r_misr   <= 16'h0;
                    r_count  <= 16'h0;
                    r_pass   <= 1'b0;
                    r_cut_in <= SEED_EFF;
                    r_state  <= ST_RUN;
                end
                ST_RUN: begin
                    r_misr  <= w_misr_next;
                    r_lfsr  <= w_lfsr_next;
                    r_count <= r_count + 16'd1;
                    if (w_last) begin
                        r_state  <= ST_COMPARE;
                        r_cut_in <= 36'h0;
                    end else begin
                        r_cut_in <= w_lfsr_next;
                    end
                end
                ST_COMPARE: begin
                    r_pass  <= (r_misr == GOLDEN_SIG);
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    // Start must drop before another session can be requested.
                    if (!start) begin
                        r_state     <= ST_IDLE;
                        r_done      <= 1'b0;
                        r_test_mode <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cut_in    <= 36'h0;
                    r_test_mode <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign cut_in    = r_cut_in;
    assign test_mode = r_test_mode;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign signature = r_misr;

endmodule
